// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 8-bit CPU: fetch/decode/execute/memory/writeback sequencing.
// Optional JZ instruction (opcode 110) enabled by defining CTRL_JZ_EN; otherwise 110 is a NOP.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_op,
    output logic       alu_b_sel,
    output logic       alu_out_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       halted,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;
    localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic [7:0] tmo_cnt;
    logic       zero_flag;
    logic       zf_capture;
    logic       tmo_hit;
    logic       rdy;
    logic       is_alu;

    // A reset cycle must not commit any memory-completion strobe.
    assign rdy    = mem_ready & ~rst;
    assign is_alu = ~opcode[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            zero_flag <= 1'b0;
            mem_err   <= 1'b0;
            tmo_cnt   <= 8'd0;
        end else begin
            state <= state_next;
            if (zf_capture)
                zero_flag <= zero;
            if (tmo_hit)
                mem_err <= 1'b1;
            // Any state change restarts the wait window for the next transfer.
            if (state_next != state)
                tmo_cnt <= 8'd0;
            else if (mem_req && !mem_ready)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        alu_op        = 3'b000;
        alu_b_sel     = 1'b0;
        alu_out_write = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        halted        = 1'b0;
        zf_capture    = 1'b0;
        tmo_hit       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (rdy) begin
                    ir_write   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_cnt == TMO) begin
                    tmo_hit    = 1'b1;
                    state_next = S_HALT;
                end
            end

            S_DECODE: begin
                if (opcode == OP_HLT)
                    state_next = S_HALT;
                else if (opcode == OP_JZ)
`ifdef CTRL_JZ_EN
                    state_next = S_EXEC;
`else
                    state_next = S_FETCH;
`endif
                else
                    state_next = S_EXEC;
            end

            S_EXEC: begin
                if (is_alu) begin
                    alu_op        = opcode;
                    alu_out_write = 1'b1;
                    zf_capture    = 1'b1;
                    state_next    = S_WB;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    alu_b_sel     = 1'b1;
                    alu_out_write = 1'b1;
                    state_next    = S_MEM;
`ifdef CTRL_JZ_EN
                end else if (opcode == OP_JZ) begin
                    // Branch target is the ALU-out value left by the previous instruction.
                    alu_b_sel     = 1'b1;
                    alu_out_write = 1'b1;
                    pc_load       = zero_flag;
                    state_next    = S_FETCH;
`endif
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                if (rdy) begin
                    if (opcode == OP_LD) begin
                        mdr_write  = 1'b1;
                        state_next = S_WB;
                    end else begin
                        state_next = S_FETCH;
                    end
                end else if (tmo_cnt == TMO) begin
                    tmo_hit    = 1'b1;
                    state_next = S_HALT;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (opcode == OP_LD);
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: driver queues expected output vectors per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_inc, pc_load;
    logic [2:0] alu_op;
    logic       alu_b_sel, alu_out_write, mdr_write, reg_write, wb_sel, halted, mem_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        e_err = 1'b0;

    mc_control_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
        .alu_out_write(alu_out_write), .mdr_write(mdr_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] v(input logic req, we, asel, irw, pci, pcl,
                                      input logic [2:0] op,
                                      input logic bsel, aow, mdr, rw, wbs, hlt);
        return {req, we, asel, irw, pci, pcl, op, bsel, aow, mdr, rw, wbs, hlt, e_err};
    endfunction

    function automatic logic [15:0] f_fetch(input logic r);
        return v(1, 0, 0, r, r, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_idle();
        return v(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_exalu(input logic [2:0] op);
        return v(0, 0, 0, 0, 0, 0, op, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_exls();
        return v(0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_exjz(input logic pl);
        return v(0, 0, 0, 0, 0, pl, 3'b000, 1, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_mem(input logic we, input logic mdr);
        return v(1, we, 1, 0, 0, 0, 3'b000, 0, 0, mdr, 0, 0, 0);
    endfunction
    function automatic logic [15:0] f_wb(input logic ld);
        return v(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, ld, 0);
    endfunction
    function automatic logic [15:0] f_halt();
        return v(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1);
    endfunction

    // One clock cycle: apply inputs just after the edge and queue what the outputs must be.
    task automatic cyc(input logic [2:0] op, input logic z, input logic r,
                       input logic [15:0] e, input string nm);
        opcode    = op;
        zero      = z;
        mem_ready = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] act, e;
        string       nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {mem_req, mem_we, addr_sel, ir_write, pc_inc, pc_load, alu_op, alu_b_sel,
                   alu_out_write, mdr_write, reg_write, wb_sel, halted, mem_err};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s actual=%b required=%b", nm, act, e);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        cyc(3'b000, 0, 0, f_fetch(0), "reset_fetch");
        rst = 1'b0;

        // ADD, zero-wait
        cyc(3'b000, 0, 1, f_fetch(1), "add_fetch");
        cyc(3'b000, 0, 1, f_idle(), "add_decode");
        cyc(3'b000, 0, 1, f_exalu(3'b000), "add_exec");
        cyc(3'b000, 0, 1, f_wb(0), "add_wb");

        // AND / OR alu_op pass-through
        cyc(3'b010, 0, 1, f_fetch(1), "and_fetch");
        cyc(3'b010, 0, 1, f_idle(), "and_decode");
        cyc(3'b010, 0, 1, f_exalu(3'b010), "and_exec");
        cyc(3'b010, 0, 1, f_wb(0), "and_wb");
        cyc(3'b011, 0, 1, f_fetch(1), "or_fetch");
        cyc(3'b011, 0, 1, f_idle(), "or_decode");
        cyc(3'b011, 0, 1, f_exalu(3'b011), "or_exec");
        cyc(3'b011, 0, 1, f_wb(0), "or_wb");

        // LD with 3-cycle memory wait
        cyc(3'b100, 0, 1, f_fetch(1), "ld_fetch");
        cyc(3'b100, 0, 1, f_idle(), "ld_decode");
        cyc(3'b100, 0, 1, f_exls(), "ld_exec");
        cyc(3'b100, 0, 0, f_mem(0, 0), "ld_mem_w1");
        cyc(3'b100, 0, 0, f_mem(0, 0), "ld_mem_w2");
        cyc(3'b100, 0, 1, f_mem(0, 1), "ld_mem_rdy");
        cyc(3'b100, 0, 1, f_wb(1), "ld_wb");

        // SUB with zero=1, then ST (flag untouched), then JZ
        cyc(3'b001, 1, 1, f_fetch(1), "sub1_fetch");
        cyc(3'b001, 1, 1, f_idle(), "sub1_decode");
        cyc(3'b001, 1, 1, f_exalu(3'b001), "sub1_exec");
        cyc(3'b001, 0, 1, f_wb(0), "sub1_wb");
        cyc(3'b101, 0, 1, f_fetch(1), "st_fetch");
        cyc(3'b101, 0, 1, f_idle(), "st_decode");
        cyc(3'b101, 0, 1, f_exls(), "st_exec");
        cyc(3'b101, 0, 1, f_mem(1, 0), "st_mem");
        cyc(3'b110, 0, 1, f_fetch(1), "jz1_fetch");
        cyc(3'b110, 0, 1, f_idle(), "jz1_decode");
`ifdef CTRL_JZ_EN
        cyc(3'b110, 0, 1, f_exjz(1), "jz1_exec_taken");
`endif
        // SUB with zero=0, then JZ not taken
        cyc(3'b001, 0, 1, f_fetch(1), "sub0_fetch");
        cyc(3'b001, 0, 1, f_idle(), "sub0_decode");
        cyc(3'b001, 0, 1, f_exalu(3'b001), "sub0_exec");
        cyc(3'b001, 1, 1, f_wb(0), "sub0_wb");
        cyc(3'b110, 1, 1, f_fetch(1), "jz0_fetch");
        cyc(3'b110, 1, 1, f_idle(), "jz0_decode");
`ifdef CTRL_JZ_EN
        cyc(3'b110, 1, 1, f_exjz(0), "jz0_exec_not_taken");
`endif

        // Ready arriving on the last allowed wait cycle still completes the fetch
        for (int i = 0; i < 15; i++) cyc(3'b000, 0, 0, f_fetch(0), "tmo_edge_wait");
        cyc(3'b000, 0, 1, f_fetch(1), "tmo_edge_ready_wins");
        cyc(3'b000, 0, 1, f_idle(), "tmo_edge_decode");
        cyc(3'b000, 0, 1, f_exalu(3'b000), "tmo_edge_exec");
        cyc(3'b000, 0, 1, f_wb(0), "tmo_edge_wb");

        // Fetch timeout: 16 unanswered cycles then HALT with mem_err
        for (int i = 0; i < 16; i++) cyc(3'b000, 0, 0, f_fetch(0), "tmo_fetch_wait");
        e_err = 1'b1;
        for (int i = 0; i < 3; i++) cyc(3'b000, 0, 1, f_halt(), "tmo_fetch_halt");
        rst = 1'b1;
        cyc(3'b000, 0, 0, f_halt(), "tmo_rst_cycle");
        rst = 1'b0;
        e_err = 1'b0;
        cyc(3'b000, 0, 0, f_fetch(0), "tmo_after_rst");

        // HLT holds regardless of mem_ready
        cyc(3'b111, 0, 1, f_fetch(1), "hlt_fetch");
        cyc(3'b111, 0, 1, f_idle(), "hlt_decode");
        for (int i = 0; i < 100; i++)
            cyc(3'(i), 1'($urandom), 1'($urandom), f_halt(), "hlt_hold");
        rst = 1'b1;
        cyc(3'b111, 0, 0, f_halt(), "hlt_rst_cycle");
        rst = 1'b0;

        // Reset asserted mid-wait in MEM
        cyc(3'b100, 0, 1, f_fetch(1), "mrst_fetch");
        cyc(3'b100, 0, 1, f_idle(), "mrst_decode");
        cyc(3'b100, 0, 1, f_exls(), "mrst_exec");
        cyc(3'b100, 0, 0, f_mem(0, 0), "mrst_mem_w1");
        cyc(3'b100, 0, 0, f_mem(0, 0), "mrst_mem_w2");
        rst = 1'b1;
        cyc(3'b100, 0, 0, f_mem(0, 0), "mrst_rst_cycle");
        rst = 1'b0;
        cyc(3'b100, 0, 0, f_fetch(0), "mrst_back_to_fetch");

        // MEM timeout on a stuck store
        cyc(3'b101, 0, 1, f_fetch(1), "mtmo_fetch");
        cyc(3'b101, 0, 1, f_idle(), "mtmo_decode");
        cyc(3'b101, 0, 1, f_exls(), "mtmo_exec");
        for (int i = 0; i < 16; i++) cyc(3'b101, 0, 0, f_mem(1, 0), "mtmo_mem_wait");
        e_err = 1'b1;
        cyc(3'b101, 0, 1, f_halt(), "mtmo_halt");
        cyc(3'b101, 0, 0, f_halt(), "mtmo_halt2");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
